// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared mode type, default parameters and packed-pattern symbol extraction
package seq_det_pkg;
  localparam int SYM_W_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int PAT_MAX_W = 256;
  localparam int SYM_MAX_W = 16;
  typedef enum logic {NON_OVERLAP = 1'b0, OVERLAP = 1'b1} seq_mode_e;
  function automatic logic [SYM_MAX_W-1:0] pat_sym(input logic [PAT_MAX_W-1:0] pat, input int sym_w, input int i);
    logic [PAT_MAX_W-1:0] sh;
    sh = pat >> (i * sym_w);
    return sh[SYM_MAX_W-1:0] & ((SYM_MAX_W'(1) << sym_w) - SYM_MAX_W'(1));
  endfunction
endpackage

// File: rtl/seq_fallback_calc.sv
// seq_fallback_calc: combinational KMP fallback length and pattern-completion detect
module seq_fallback_calc
  import seq_det_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ST_W  = $clog2(DEPTH + 1)
) (
  input  logic [ST_W-1:0]        s,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic [DEPTH*SYM_W-1:0] pattern,
  input  logic [ST_W-1:0]        len,
  output logic [ST_W-1:0]        k,
  output logic                   match
);
  function automatic logic [SYM_W-1:0] sym(input logic [DEPTH*SYM_W-1:0] p, input int i);
    return SYM_W'(pat_sym(PAT_MAX_W'(p), SYM_W, i));
  endfunction
  logic [DEPTH-1:0] ok;
  assign ok[0] = 1'b1;
  for (genvar j = 1; j < DEPTH; j++) begin : g_cand
    logic v;
    // candidate j: history suffix of length j equals the pattern prefix of length j
    always_comb begin
      v = (j <= int'(s) + 1) && (j < int'(len)) && (in_sym == sym(pattern, j - 1));
      for (int m = 0; m < j - 1; m++) v = v && (sym(pattern, int'(s) + 1 - j + m) == sym(pattern, m));
    end
    assign ok[j] = v;
  end
  // longest valid candidate wins; completion when the last pattern symbol arrives
  always_comb begin
    k = '0;
    for (int i = 1; i < DEPTH; i++) k = ok[i] ? ST_W'(i) : k;
    match = (int'(s) + 1 == int'(len)) && (in_sym == sym(pattern, int'(s)));
  end
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-programmable symbol sequence detector with match counter
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ST_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   cfg_load,
  input  logic [ST_W-1:0]        cfg_len,
  input  logic [DEPTH*SYM_W-1:0] cfg_pattern,
  input  logic                   cfg_overlap,
  output logic                   Q,
  output logic [CNT_W-1:0]       match_count,
  output logic                   armed,
  output logic                   cfg_err,
  output logic [ST_W-1:0]        state_var,
  output logic [ST_W-1:0]        next_state_var
);
  logic [DEPTH*SYM_W-1:0] pat_q, pat_d;
  logic [ST_W-1:0] len_q, len_d, s_q, s_d, k;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_mode_e mode_q, mode_d;
  logic armed_q, armed_d, q_q, q_d, err_q, err_d;
  logic match, cfg_ok, step, hit;
  seq_fallback_calc #(.SYM_W(SYM_W), .DEPTH(DEPTH), .ST_W(ST_W)) u_fb (
    .s(s_q),
    .in_sym(in_sym),
    .pattern(pat_q),
    .len(len_q),
    .k(k),
    .match(match)
  );
  // config takes priority over the stream; a symbol alongside cfg_load is dropped
  always_comb begin
    cfg_ok  = cfg_load && (cfg_len != '0) && (int'(cfg_len) <= DEPTH);
    step    = armed_q && in_valid && !cfg_load;
    hit     = step && match;
    s_d     = (cfg_ok || (hit && mode_q == NON_OVERLAP)) ? '0 : step ? k : s_q;
    pat_d   = cfg_ok ? cfg_pattern : pat_q;
    len_d   = cfg_ok ? cfg_len : len_q;
    mode_d  = cfg_ok ? seq_mode_e'(cfg_overlap) : mode_q;
    armed_d = armed_q || cfg_ok;
    q_d     = hit;
    err_d   = cfg_load && !cfg_ok;
    cnt_d   = cfg_ok ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, configuration and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= ST_W'(1);
      mode_q  <= NON_OVERLAP;
      armed_q <= 1'b0;
      s_q     <= '0;
      q_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      s_q     <= s_d;
      q_q     <= q_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign Q              = q_q;
  assign match_count    = cnt_q;
  assign armed          = armed_q;
  assign cfg_err        = err_q;
  assign state_var      = s_q;
  assign next_state_var = s_d;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: randomized scoreboard bench against a stream-history reference model
module tb_seq_pattern_detector;
  localparam int SYM_W = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int ST_W  = $clog2(DEPTH + 1);
  localparam int PW    = DEPTH * SYM_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [SYM_W-1:0] in_sym = '0;
  logic [ST_W-1:0] cfg_len = '0;
  logic [PW-1:0] cfg_pattern = '0;
  logic Q, armed, cfg_err;
  logic [CNT_W-1:0] match_count;
  logic [ST_W-1:0] state_var, next_state_var;

  always #5 clk = ~clk;

  seq_pattern_detector #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_load(cfg_load), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .Q(Q), .match_count(match_count), .armed(armed), .cfg_err(cfg_err),
    .state_var(state_var), .next_state_var(next_state_var)
  );

  typedef struct { int due; int s; } nsv_t;
  typedef struct { int due; bit q; int cnt; int s; bit armed; bit err; } reg_t;
  nsv_t nsv_q[$];
  reg_t reg_q[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int m_pat[DEPTH];
  int m_len = 1, m_cnt = 0, m_s = 0;
  bit m_ov = 0, m_armed = 0;
  int hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string n, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  function automatic bit suffix_ok(int q[$], int j);
    if (j > q.size()) return 0;
    for (int i = 0; i < j; i++) if (q[q.size() - j + i] != m_pat[i]) return 0;
    return 1;
  endfunction

  task automatic drive(bit r, bit v, int sym, bit ld, int len, logic [PW-1:0] p, bit ov);
    int tmp[$];
    int ns;
    bit hit, vcfg, stp;
    @(posedge clk);
    #1;
    reset = r; in_valid = v; in_sym = SYM_W'(sym); cfg_load = ld;
    cfg_len = ST_W'(len); cfg_pattern = p; cfg_overlap = ov;
    vcfg = ld && len >= 1 && len <= DEPTH;
    stp = !ld && m_armed && v;
    hit = 0; ns = m_s; tmp = hist;
    if (vcfg) ns = 0;
    else if (stp) begin
      tmp.push_back(sym);
      if (tmp.size() > DEPTH) void'(tmp.pop_front());
      hit = suffix_ok(tmp, m_len);
      if (hit && !m_ov) tmp.delete();
      ns = 0;
      for (int j = 1; j < m_len; j++) if (suffix_ok(tmp, j)) ns = j;
    end
    if (!r) nsv_q.push_back('{cyc, ns});
    if (r) begin
      m_armed = 0; m_cnt = 0; m_s = 0; m_len = 1; m_ov = 0; hist.delete();
      for (int i = 0; i < DEPTH; i++) m_pat[i] = 0;
    end else if (vcfg) begin
      for (int i = 0; i < DEPTH; i++) m_pat[i] = int'(p[i*SYM_W +: SYM_W]);
      m_len = len; m_ov = ov; m_armed = 1; m_cnt = 0; m_s = 0; hist.delete();
    end else if (stp) begin
      hist = tmp; m_s = ns;
      if (hit && m_cnt < CMAX) m_cnt++;
    end
    reg_q.push_back('{cyc + 1, hit && !r, m_cnt, m_s, m_armed, ld && !vcfg && !r});
  endtask

  always @(negedge clk) begin
    while (nsv_q.size() > 0 && nsv_q[0].due == cyc) begin
      cmp("next_state_var", int'(next_state_var), nsv_q[0].s);
      void'(nsv_q.pop_front());
    end
    while (reg_q.size() > 0 && reg_q[0].due == cyc) begin
      cmp("Q", int'(Q), int'(reg_q[0].q));
      cmp("match_count", int'(match_count), reg_q[0].cnt);
      cmp("state_var", int'(state_var), reg_q[0].s);
      cmp("armed", int'(armed), int'(reg_q[0].armed));
      cmp("cfg_err", int'(cfg_err), int'(reg_q[0].err));
      void'(reg_q.pop_front());
    end
  end

  function automatic logic [PW-1:0] pk(int a, int b, int c, int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  task automatic ld(int len, logic [PW-1:0] p, bit ov);
    drive(0, 0, 0, 1, len, p, ov);
  endtask
  task automatic sy(int s);
    drive(0, 1, s, 0, 0, '0, 0);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s1[6] = '{1, 2, 0, 1, 1, 2};
    int s2[5] = '{1, 0, 1, 0, 1};
    int s3[4] = '{1, 1, 1, 2};
    drive(1, 0, 0, 0, 0, '0, 0);
    ld(2, pk(1, 2, 0, 0), 0);
    foreach (s1[i]) sy(s1[i]);
    ld(3, pk(1, 0, 1, 0), 1);
    foreach (s2[i]) sy(s2[i]);
    ld(3, pk(1, 0, 1, 0), 0);
    foreach (s2[i]) sy(s2[i]);
    ld(3, pk(1, 1, 2, 0), 0);
    foreach (s3[i]) sy(s3[i]);
    foreach (s3[i]) begin sy(s3[i]); idle(3); end
    drive(1, 0, 0, 0, 0, '0, 0);
    ld(0, pk(0, 0, 0, 0), 0);
    ld(5, pk(0, 0, 0, 0), 0);
    for (int i = 0; i < 3; i++) sy(0);
    ld(1, pk(3, 0, 0, 0), 0);
    for (int i = 0; i < 6; i++) sy(3);
    ld(2, pk(1, 2, 0, 0), 0);
    sy(1);
    drive(1, 1, 2, 0, 0, '0, 0);
    idle(1);
    ld(2, pk(1, 2, 0, 0), 1);
    sy(1);
    ld(2, pk(1, 2, 0, 0), 1);
    sy(2);
    sy(1);
    drive(0, 1, 2, 1, 2, pk(1, 2, 0, 0), 0);
    sy(1);
    sy(2);
    drive(0, 1, 1, 1, 2, pk(1, 2, 0, 0), 0);
    for (int n = 0; n < 1500; n++) begin
      bit r, l, v, ov;
      int len, sym;
      logic [PW-1:0] p;
      r = $urandom_range(0, 99) == 0;
      l = $urandom_range(0, 14) == 0;
      v = $urandom_range(0, 9) < 7;
      ov = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 7);
      sym = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1);
      for (int i = 0; i < DEPTH; i++)
        p[i*SYM_W +: SYM_W] = SYM_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1));
      drive(r, v, sym, l, len, p, ov);
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (nsv_q.size() + reg_q.size() != 0) cmp("queue_drain", nsv_q.size() + reg_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
